// File: rtl/bus_demux4_if.sv
// Initiator-to-target bus bundle for the 1:4 request demultiplexer.
// The slave modport is the demux view; master is the initiator/target side.
interface bus_demux4_if #(
    parameter int N = 32
);
    logic           req_valid;
    logic           req_ready;
    logic [N-1:0]   req_addr;
    logic [N-1:0]   req_wdata;
    logic           req_we;
    logic [3:0]     tgt_sel;
    logic [N-1:0]   tgt_addr;
    logic [N-1:0]   tgt_wdata;
    logic           tgt_we;
    logic [3:0]     tgt_ack;
    logic [4*N-1:0] tgt_rdata;
    logic           resp_valid;
    logic [N-1:0]   resp_rdata;
    logic           resp_err;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_we, tgt_ack, tgt_rdata,
        output req_ready, tgt_sel, tgt_addr, tgt_wdata, tgt_we,
               resp_valid, resp_rdata, resp_err
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_we, tgt_ack, tgt_rdata,
        input  req_ready, tgt_sel, tgt_addr, tgt_wdata, tgt_we,
               resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/bus_demux4.sv
// Routes one request at a time to one of four targets chosen by the top two
// address bits, waits for that target's ack (or times out) and returns a response.
//
// state  | meaning
// IDLE   | ready for a request; latches it on req_valid
// ACCESS | target selected, waiting for its ack or for the timeout
// RESP   | one-cycle response pulse, then back to IDLE
module bus_demux4 #(
    parameter int N       = 32,
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    bus_demux4_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t       state, state_nxt;
    logic [1:0]   idx;
    logic [7:0]   wait_cnt;
    logic [N-1:0] addr_q;
    logic [N-1:0] wdata_q;
    logic         we_q;
    logic [N-1:0] rdata_q;
    logic         err_q;
    logic         ack_hit;
    logic         tmo_hit;
    logic [N-1:0] sel_rdata;

    assign ack_hit   = bus.tgt_ack[idx];
    assign tmo_hit   = (wait_cnt == 8'(TIMEOUT - 1));
    assign sel_rdata = bus.tgt_rdata[int'(idx) * N +: N];

    assign bus.tgt_addr   = addr_q;
    assign bus.tgt_wdata  = wdata_q;
    assign bus.tgt_we     = we_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            idx      <= 2'd0;
            wait_cnt <= 8'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q   <= bus.req_addr;
                        wdata_q  <= bus.req_wdata;
                        we_q     <= bus.req_we;
                        idx      <= bus.req_addr[N-1:N-2];
                        wait_cnt <= 8'd0;
                    end
                end
                ACCESS: begin
                    // an ack in the last allowed cycle still counts as success
                    if (ack_hit) begin
                        rdata_q <= sel_rdata;
                        err_q   <= 1'b0;
                    end else if (tmo_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt      = state;
        bus.req_ready  = 1'b0;
        bus.tgt_sel    = 4'b0000;
        bus.resp_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_nxt = ACCESS;
            end
            ACCESS: begin
                bus.tgt_sel = 4'b0001 << idx;
                if (ack_hit || tmo_hit) state_nxt = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_bus_demux4.sv
// Directed and random transactions against a transaction-level model of the
// demux: target index, access length and response are derived per request.
module tb_bus_demux4;
    localparam int N       = 32;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_demux4_if #(.N(N)) bus_if ();

    bus_demux4 #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int total = 0;
    int bad   = 0;
    logic [N-1:0] last_rd  = '0;
    logic         last_err = 1'b0;

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic rand_rdata(output logic [4*N-1:0] rd);
        for (int k = 0; k < 4; k++) rd[k*N +: N] = $urandom;
    endtask

    task automatic drive_noise_req();
        bus_if.req_valid = 1'($urandom);
        bus_if.req_addr  = $urandom;
        bus_if.req_wdata = $urandom;
        bus_if.req_we    = 1'($urandom);
    endtask

    // Entered and left at a falling edge with the DUT idle.
    // ack_at: ACCESS cycle (0-based) carrying the right ack; >= TIMEOUT means none.
    task automatic txn(input logic [N-1:0] addr, input logic [N-1:0] wdata, input logic we,
                       input int ack_at, input logic [3:0] noise,
                       input bit use_fix, input logic [N-1:0] fix_rd);
        logic [1:0]     idx;
        logic [3:0]     onehot;
        logic [4*N-1:0] rd;
        logic [N-1:0]   exp_rd;
        logic           exp_err;
        int             len;
        idx     = addr[N-1:N-2];
        onehot  = 4'b0001 << idx;
        len     = (ack_at < TIMEOUT) ? ack_at + 1 : TIMEOUT;
        exp_rd  = '0;
        exp_err = 1'b1;

        chk("idle_ready", N'(bus_if.req_ready), N'(1));
        chk("idle_sel", N'(bus_if.tgt_sel), N'(0));
        chk("idle_valid", N'(bus_if.resp_valid), N'(0));
        bus_if.req_valid = 1'b1;
        bus_if.req_addr  = addr;
        bus_if.req_wdata = wdata;
        bus_if.req_we    = we;
        bus_if.tgt_ack   = 4'b0000;

        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            chk("acc_sel", N'(bus_if.tgt_sel), N'(onehot));
            chk("acc_ready", N'(bus_if.req_ready), N'(0));
            chk("acc_valid", N'(bus_if.resp_valid), N'(0));
            chk("acc_addr", bus_if.tgt_addr, addr);
            chk("acc_wdata", bus_if.tgt_wdata, wdata);
            chk("acc_we", N'(bus_if.tgt_we), N'(we));
            chk("acc_hold_rd", bus_if.resp_rdata, last_rd);
            drive_noise_req();
            rand_rdata(rd);
            if (use_fix) rd[int'(idx) * N +: N] = fix_rd;
            bus_if.tgt_rdata = rd;
            if (i == ack_at) begin
                bus_if.tgt_ack = noise | onehot;
                exp_rd  = rd[int'(idx) * N +: N];
                exp_err = 1'b0;
            end else begin
                bus_if.tgt_ack = noise & ~onehot;
            end
        end

        @(negedge clk);
        chk("resp_valid", N'(bus_if.resp_valid), N'(1));
        chk("resp_rdata", bus_if.resp_rdata, exp_rd);
        chk("resp_err", N'(bus_if.resp_err), N'(exp_err));
        chk("resp_sel", N'(bus_if.tgt_sel), N'(0));
        chk("resp_ready", N'(bus_if.req_ready), N'(0));
        bus_if.tgt_ack = 4'($urandom);
        drive_noise_req();
        last_rd  = exp_rd;
        last_err = exp_err;

        @(negedge clk);
        chk("post_valid", N'(bus_if.resp_valid), N'(0));
        chk("post_hold_rd", bus_if.resp_rdata, last_rd);
        chk("post_hold_err", N'(bus_if.resp_err), N'(last_err));
        chk("post_addr", bus_if.tgt_addr, addr);
        bus_if.tgt_ack = 4'b0000;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ready"}, N'(bus_if.req_ready), N'(1));
        chk({tag, "_sel"}, N'(bus_if.tgt_sel), N'(0));
        chk({tag, "_addr"}, bus_if.tgt_addr, '0);
        chk({tag, "_wdata"}, bus_if.tgt_wdata, '0);
        chk({tag, "_we"}, N'(bus_if.tgt_we), N'(0));
        chk({tag, "_valid"}, N'(bus_if.resp_valid), N'(0));
        chk({tag, "_rdata"}, bus_if.resp_rdata, '0);
        chk({tag, "_err"}, N'(bus_if.resp_err), N'(0));
    endtask

    initial begin
        logic [4*N-1:0] rd;
        rst              = 1'b0;
        bus_if.req_valid = 1'b1;
        bus_if.req_addr  = 32'h4000_0000;
        bus_if.req_wdata = 32'h5555_AAAA;
        bus_if.req_we    = 1'b1;
        bus_if.tgt_ack   = 4'b1111;
        rand_rdata(rd);
        bus_if.tgt_rdata = rd;
        repeat (3) @(negedge clk);
        chk_reset_values("rst");
        rst              = 1'b1;
        bus_if.req_valid = 1'b0;
        bus_if.tgt_ack   = 4'b0000;
        @(negedge clk);

        // read, ack in the first ACCESS cycle
        txn(32'h8000_0010, 32'h0, 1'b0, 0, 4'b0000, 1'b1, 32'hDEAD_BEEF);
        // write, ack after three wait cycles
        txn(32'hC000_0004, 32'h1234_5678, 1'b1, 3, 4'b0000, 1'b0, '0);
        // timeout, then ack in the final allowed cycle
        txn(32'h4000_0000, 32'h0, 1'b0, TIMEOUT, 4'b0000, 1'b0, '0);
        txn(32'h4000_0020, 32'h0, 1'b0, TIMEOUT - 1, 4'b0000, 1'b1, 32'hCAFE_F00D);
        // acks on other targets are ignored
        txn(32'h0000_0100, 32'h0, 1'b0, 5, 4'b1110, 1'b0, '0);
        txn(32'h0000_0200, 32'h0, 1'b1, TIMEOUT, 4'b1110, 1'b0, '0);

        for (int k = 0; k < 40; k++) begin
            txn($urandom, $urandom, 1'($urandom), int'($urandom_range(0, TIMEOUT + 1)),
                4'($urandom), 1'b0, '0);
        end

        // reset in the second ACCESS cycle with ack and req_valid present
        bus_if.req_valid = 1'b1;
        bus_if.req_addr  = 32'h8000_0040;
        bus_if.req_wdata = 32'h0BAD_F00D;
        bus_if.req_we    = 1'b1;
        @(negedge clk);
        chk("rmid_sel1", N'(bus_if.tgt_sel), N'(4'b0100));
        @(negedge clk);
        chk("rmid_sel2", N'(bus_if.tgt_sel), N'(4'b0100));
        rst              = 1'b0;
        bus_if.tgt_ack   = 4'b1111;
        bus_if.req_valid = 1'b1;
        @(negedge clk);
        chk_reset_values("rmid");
        rst              = 1'b1;
        bus_if.tgt_ack   = 4'b0000;
        bus_if.req_valid = 1'b0;
        @(negedge clk);
        chk("rmid_after_valid", N'(bus_if.resp_valid), N'(0));
        chk("rmid_after_ready", N'(bus_if.req_ready), N'(1));
        last_rd  = '0;
        last_err = 1'b0;

        txn(32'h4000_0008, 32'h0, 1'b0, 2, 4'b1101, 1'b0, '0);
        bus_if.req_valid = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bus_demux4.md
BUS_DEMUX4 -- requirements
Module: bus_demux4

Interface
REQ-001 Parameter N, default 32, SHALL set the address and data width.
REQ-002 Parameter TIMEOUT, default 16, range 2..255, SHALL set the maximum cycles a target access may wait for an acknowledge.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-low reset (sampled on rising clk; rst=0 resets).
REQ-005 req_valid  input  1  SHALL indicate that the initiator presents a request.
REQ-006 req_ready  output  1  SHALL indicate that the block accepts a request this cycle.
REQ-007 req_addr  input  N  SHALL be the request address; bits [N-1:N-2] select the target.
REQ-008 req_wdata  input  N  SHALL be the request write data.
REQ-009 req_we  input  1  SHALL be 1 for a write and 0 for a read.
REQ-010 tgt_sel  output  4  SHALL be the one-hot target select; bit k addresses target k.
REQ-011 tgt_addr  output  N  SHALL be the latched request address.
REQ-012 tgt_wdata  output  N  SHALL be the latched write data.
REQ-013 tgt_we  output  1  SHALL be the latched write enable.
REQ-014 tgt_ack  input  4  SHALL carry per-target acknowledges; bit k from target k.
REQ-015 tgt_rdata  input  4*N  SHALL carry read data; slice [k*N +: N] from target k.
REQ-016 resp_valid  output  1  SHALL mark a one-cycle response.
REQ-017 resp_rdata  output  N  SHALL be the response read data.
REQ-018 resp_err  output  1  SHALL be 1 when the response is a timeout.

Function
REQ-019 The block SHALL implement three states: IDLE, ACCESS, RESP.
REQ-020 IDLE: req_ready=1, tgt_sel=0, resp_valid=0; on req_valid=1 the block SHALL latch addr, wdata, we and index=req_addr[N-1:N-2], clear the wait counter, and enter ACCESS.
REQ-021 ACCESS: req_ready=0; tgt_sel SHALL equal 1<<index; tgt_addr/tgt_wdata/tgt_we SHALL hold the latched values, stable for the whole state.
REQ-022 ACCESS: if tgt_ack[index]=1, the block SHALL capture tgt_rdata slice index into resp_rdata, set resp_err=0, and enter RESP.
REQ-023 Acknowledges on bits other than index SHALL be ignored.
REQ-024 ACCESS: the wait counter SHALL increment every cycle without ack; when TIMEOUT ACCESS cycles elapse without ack, the block SHALL set resp_rdata=0, resp_err=1, and enter RESP.
REQ-025 Ack in the final (TIMEOUT-th) ACCESS cycle SHALL win over timeout (resp_err=0).
REQ-026 RESP: resp_valid=1 for exactly one cycle, req_ready=0, tgt_sel=0; next state SHALL be IDLE.
REQ-027 resp_rdata and resp_err SHALL hold their values until the next response is captured.
REQ-028 Latency: request accepted in cycle T, tgt_sel asserted from T+1; ack in cycle T+1+j SHALL give resp_valid in T+2+j; minimum 3 cycles per transaction.
REQ-029 For writes, resp_rdata SHALL still capture the acknowledged target's tgt_rdata slice.
REQ-030 Requests presented while req_ready=0 SHALL not be accepted or latched.

Reset
REQ-031 With rst=0 at a rising edge the block SHALL enter IDLE and drive req_ready=1, tgt_sel=0, tgt_addr=0, tgt_wdata=0, tgt_we=0, resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
REQ-032 Reset during ACCESS or RESP SHALL abort the transaction with no response issued.
REQ-033 Reset SHALL take priority over every concurrent event, including req_valid and tgt_ack.

Verification
REQ-034 Read: req_addr=0x8000_0010, req_we=0 at T; tgt_ack[2]=1 with slice2=0xDEAD_BEEF at T+1 -> tgt_sel=4'b0100 at T+1, resp_valid=1, resp_rdata=0xDEADBEEF, resp_err=0 at T+2.
REQ-035 Write: req_addr=0xC000_0004, req_wdata=0x1234_5678, req_we=1; ack[3] after 3 wait cycles -> tgt_sel=4'b1000, tgt_we=1, tgt_wdata=0x12345678 stable 4 cycles, resp_valid 1 cycle later.
REQ-036 Timeout: target 1 selected, tgt_ack=0 -> tgt_sel=4'b0010 for exactly 16 cycles, then resp_valid=1, resp_err=1, resp_rdata=0; ack on cycle 16 instead -> resp_err=0.
REQ-037 Wrong ack: target 0 selected, tgt_ack=4'b1110 for 5 cycles then 4'b0001 -> response only after the bit-0 ack.
REQ-038 Reset mid-op: rst=0 in second ACCESS cycle -> next cycle all outputs at REQ-031 values, no resp_valid; back-to-back requests with req_valid held high -> accepted only in IDLE cycles.
